// File: rtl/group_fifo_push_arbiter.sv
// rtl/group_fifo_push_arbiter.sv - round-robin push arbiter with per-producer quota and owner-tag FIFO
module group_fifo_push_arbiter #(
    parameter int REQS      = 4,
    parameter int GID_WIDTH = 16,
    parameter int DEPTH     = 8,
    parameter int QUOTA     = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [REQS-1:0]                     req_valid,
    input  logic [REQS*GID_WIDTH-1:0]           req_gid,
    output logic [REQS-1:0]                     req_ready,
    output logic                                fifo_push_valid,
    output logic [GID_WIDTH-1:0]                fifo_push_gid,
    input  logic                                fifo_push_ready,
    input  logic                                fifo_pop_valid,
    output logic                                pop_owner_valid,
    output logic [$clog2(REQS)-1:0]             pop_owner,
    input  logic                                drain,
    output logic                                drain_done,
    output logic [$clog2(DEPTH+1)-1:0]          tracked_count,
    output logic [REQS*$clog2(QUOTA+1)-1:0]     outstanding,
    output logic                                protocol_err
);
    localparam int IDX_W = $clog2(REQS);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int OUT_W = $clog2(QUOTA+1);
    localparam logic [OUT_W-1:0] QUOTA_C  = OUT_W'(QUOTA);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH-1);
    localparam logic [IDX_W-1:0] REQ_LAST = IDX_W'(REQS-1);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic [REQS-1:0]  eligible;
    logic             any_elig;
    logic [OUT_W-1:0] out_cnt [REQS];
    logic [IDX_W-1:0] tag_mem [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;
    logic             tag_empty, tag_full;
    logic             grant, push_ok, pop_ok;
    logic [IDX_W-1:0] head_tag;

    assign tag_empty = (count == '0);
    assign tag_full  = (count == DEPTH_C);
    assign head_tag  = tag_mem[head];

    always_comb begin
        for (int i = 0; i < REQS; i++) begin
            eligible[i] = req_valid[i] && (out_cnt[i] < QUOTA_C) && !drain;
        end
    end

    // Scan upward from rr_ptr with wrap; first eligible producer wins.
    always_comb begin : pick
        int idx;
        idx      = 0;
        winner   = '0;
        any_elig = 1'b0;
        for (int k = 0; k < REQS; k++) begin
            idx = (int'(rr_ptr) + k) % REQS;
            if (!any_elig && eligible[idx]) begin
                any_elig = 1'b1;
                winner   = IDX_W'(idx);
            end
        end
    end

    assign grant           = any_elig && fifo_push_ready;
    assign push_ok         = grant && !tag_full;
    assign pop_ok          = fifo_pop_valid && !tag_empty;
    assign fifo_push_valid = grant;
    assign fifo_push_gid   = req_gid[winner*GID_WIDTH +: GID_WIDTH];
    assign pop_owner_valid = pop_ok;
    assign pop_owner       = head_tag;
    assign tracked_count   = count;

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[winner] = 1'b1;
    end

    always_comb begin
        outstanding = '0;
        for (int i = 0; i < REQS; i++) begin
            outstanding[i*OUT_W +: OUT_W] = out_cnt[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            protocol_err <= 1'b0;
            drain_done   <= 1'b0;
            for (int i = 0; i < REQS; i++) out_cnt[i] <= '0;
            for (int j = 0; j < DEPTH; j++) tag_mem[j] <= '0;
        end else begin
            drain_done <= drain && tag_empty;
            if ((fifo_pop_valid && tag_empty) || (grant && tag_full)) protocol_err <= 1'b1;
            if (grant) rr_ptr <= (winner == REQ_LAST) ? '0 : winner + 1'b1;
            if (push_ok) begin
                tag_mem[tail] <= winner;
                tail          <= (tail == PTR_LAST) ? '0 : tail + 1'b1;
            end
            if (pop_ok) head <= (head == PTR_LAST) ? '0 : head + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A push and pop hitting the same producer cancel out.
            for (int i = 0; i < REQS; i++) begin
                if (push_ok && winner == IDX_W'(i) && !(pop_ok && head_tag == IDX_W'(i)))
                    out_cnt[i] <= out_cnt[i] + 1'b1;
                else if (pop_ok && head_tag == IDX_W'(i) && !(push_ok && winner == IDX_W'(i)))
                    out_cnt[i] <= out_cnt[i] - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_group_fifo_push_arbiter.sv
// tb/tb_group_fifo_push_arbiter.sv - scoreboard bench for group_fifo_push_arbiter
module tb_group_fifo_push_arbiter;
    localparam int REQS = 4, GW = 16, DEPTH = 8, QUOTA = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [REQS-1:0]  req_valid;
    logic [REQS*GW-1:0] req_gid;
    logic [REQS-1:0]  req_ready;
    logic             fifo_push_valid;
    logic [GW-1:0]    fifo_push_gid;
    logic             fifo_push_ready;
    logic             fifo_pop_valid;
    logic             pop_owner_valid;
    logic [1:0]       pop_owner;
    logic             drain;
    logic             drain_done;
    logic [3:0]       tracked_count;
    logic [11:0]      outstanding;
    logic             protocol_err;

    group_fifo_push_arbiter #(.REQS(REQS), .GID_WIDTH(GW), .DEPTH(DEPTH), .QUOTA(QUOTA)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_gid(req_gid),
        .req_ready(req_ready), .fifo_push_valid(fifo_push_valid), .fifo_push_gid(fifo_push_gid),
        .fifo_push_ready(fifo_push_ready), .fifo_pop_valid(fifo_pop_valid),
        .pop_owner_valid(pop_owner_valid), .pop_owner(pop_owner), .drain(drain),
        .drain_done(drain_done), .tracked_count(tracked_count), .outstanding(outstanding),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    logic [GW-1:0] cur_gid [REQS];
    always_comb begin
        for (int i = 0; i < REQS; i++) req_gid[i*GW +: GW] = cur_gid[i];
    end

    int n_checks = 0;
    int n_fail   = 0;
    int m_rr, m_cnt;
    int m_out [REQS];
    bit m_err, m_dd;
    int q[$];
    int gl[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_rr = 0; m_cnt = 0; m_err = 0; m_dd = 0;
        q.delete();
        for (int i = 0; i < REQS; i++) m_out[i] = 0;
    endtask

    task automatic cycle();
        int w, idx, o;
        bit any, g, p, pre_full;
        #1;
        any = 0; w = 0;
        for (int k = 0; k < REQS; k++) begin
            idx = (m_rr + k) % REQS;
            if (!any && req_valid[idx] && m_out[idx] < QUOTA && !drain) begin
                any = 1; w = idx;
            end
        end
        g = any && fifo_push_ready;
        p = fifo_pop_valid && (q.size() > 0);
        check("req_ready", req_ready, g ? (64'd1 << w) : 64'd0);
        check("push_valid", fifo_push_valid, g);
        if (g) check("push_gid", fifo_push_gid, cur_gid[w]);
        check("pop_owner_valid", pop_owner_valid, p);
        if (p) check("pop_owner", pop_owner, q[0]);
        check("tracked_count", tracked_count, m_cnt);
        for (int i = 0; i < REQS; i++) check("outstanding", outstanding[i*3 +: 3], m_out[i]);
        check("protocol_err", protocol_err, m_err);
        check("drain_done", drain_done, m_dd);
        @(posedge clk);
        pre_full = (m_cnt == DEPTH);
        m_dd = drain && (m_cnt == 0);
        if (fifo_pop_valid && q.size() == 0) m_err = 1;
        if (g && pre_full) m_err = 1;
        if (p) begin
            o = q.pop_front();
            m_out[o]--; m_cnt--;
        end
        if (g) begin
            m_rr = (w + 1) % REQS;
            cur_gid[w] = cur_gid[w] + 1'b1;
            gl.push_back(w);
            if (!pre_full) begin
                q.push_back(w); m_out[w]++; m_cnt++;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] rv, input bit pr, input bit pv, input bit dr, input int n);
        req_valid = rv; fifo_push_ready = pr; fifo_pop_valid = pv; drain = dr;
        for (int c = 0; c < n; c++) cycle();
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; fifo_push_ready = 1'b1; fifo_pop_valid = 1'b0; drain = 1'b0;
        for (int i = 0; i < REQS; i++) cur_gid[i] = 16'h1000 * (i + 1);
        model_reset();
        #1;
        check("rst_tracked", tracked_count, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_perr", protocol_err, 0);
        check("rst_drain_done", drain_done, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // all producers, one pop per cycle
        drive(4'b1111, 1, 0, 0, 1);
        drive(4'b1111, 1, 1, 0, 7);
        drive(4'b0000, 1, 1, 0, 1);
        for (int i = 0; i < 8; i++) check("rr_order", gl[i], i % 4);

        // quota on producer 2
        drive(4'b0100, 1, 0, 0, 5);
        check("quota_out2", outstanding[6 +: 3], 4);
        check("quota_block", req_ready, 4'b0000);
        drive(4'b0100, 1, 1, 0, 1);
        drive(4'b0100, 1, 0, 0, 1);
        drive(4'b0000, 1, 1, 0, 4);

        // push_ready low blocks grants and holds rr_ptr
        drive(4'b1111, 0, 0, 0, 2);
        drive(4'b1111, 1, 0, 0, 1);
        drive(4'b0000, 1, 1, 0, 1);

        // simultaneous grant and pop for producer 1
        drive(4'b0010, 1, 0, 0, 2);
        drive(4'b0010, 1, 1, 0, 1);
        check("simul_out1", outstanding[3 +: 3], 2);
        check("simul_tracked", tracked_count, 2);
        drive(4'b0000, 1, 1, 0, 2);

        // fill, then drain
        drive(4'b1111, 1, 0, 0, 8);
        check("full_tracked", tracked_count, 8);
        drive(4'b1111, 1, 1, 1, 8);
        check("drain_pre", drain_done, 0);
        drive(4'b1111, 1, 0, 1, 1);
        check("drain_done", drain_done, 1);
        drive(4'b0000, 1, 0, 0, 2);

        // pop on empty tag FIFO is sticky
        drive(4'b0000, 1, 1, 0, 1);
        drive(4'b0000, 1, 0, 0, 2);
        check("perr_sticky", protocol_err, 1);
        drive(4'b1111, 1, 0, 0, 3);

        // asynchronous reset mid-stream
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_tracked", tracked_count, 0);
        check("arst_outstanding", outstanding, 0);
        check("arst_perr", protocol_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst_first_grant", req_ready, 4'b0001);
        drive(4'b1111, 1, 0, 0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
